// File: rtl/add_pipe_pkg.sv
// rtl/add_pipe_pkg.sv - shared mode encodings and default geometry for add_pipe
package add_pipe_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_INC = 2'd1,
        MODE_SUB = 2'd2,
        MODE_DEC = 2'd3
    } mode_e;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational SW-bit ripple-carry slice with carry into its top bit
module add_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [SW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SW; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined add/inc/sub/dec, one SW-bit slice resolved per stage
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] x_map;
    logic [WIDTH-1:0] y_map;
    logic             c_map;

    // Every mode collapses onto X + Y + C so the slices never see the mode.
    always_comb begin
        x_map = a;
        y_map = b;
        c_map = cin;
        unique case (mode_e'(mode))
            MODE_ADD: begin
                y_map = b;
                c_map = cin;
            end
            MODE_INC: begin
                y_map = '0;
                c_map = 1'b1;
            end
            MODE_SUB: begin
                y_map = ~b;
                c_map = 1'b1;
            end
            MODE_DEC: begin
                y_map = '1;
                c_map = 1'b0;
            end
        endcase
    end

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int RW = (STAGES - s) * SW;  // operand bits still unconsumed entering this stage
        localparam int DW = (s + 1) * SW;       // result bits resolved once this stage completes

        logic [RW-1:0] xi;
        logic [RW-1:0] yi;
        logic          ci;
        logic          vi;
        logic [SW-1:0] s_slice;
        logic          co;
        logic          cm;
        logic [DW-1:0] res_new;
        logic [DW-1:0] res_q;
        logic [DW-1:0] res_d;
        logic          valid_q;
        logic          valid_d;
        logic          carry_q;
        logic          carry_d;

        if (s == 0) begin : g_head
            assign xi      = x_map;
            assign yi      = y_map;
            assign ci      = c_map;
            assign vi      = in_valid && in_ready;
            assign res_new = s_slice;
        end else begin : g_body
            assign xi      = g_stage[s-1].g_fwd.x_q;
            assign yi      = g_stage[s-1].g_fwd.y_q;
            assign ci      = g_stage[s-1].carry_q;
            assign vi      = g_stage[s-1].valid_q;
            assign res_new = {s_slice, g_stage[s-1].res_q};
        end

        add_slice #(.SW(SW)) u_slice (
            .x        (xi[SW-1:0]),
            .y        (yi[SW-1:0]),
            .ci       (ci),
            .s        (s_slice),
            .co       (co),
            .c_msb_in (cm)
        );

        always_comb begin
            valid_d = en ? vi      : valid_q;
            carry_d = en ? co      : carry_q;
            res_d   = en ? res_new : res_q;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [RW-SW-1:0] x_q;
            logic [RW-SW-1:0] x_d;
            logic [RW-SW-1:0] y_q;
            logic [RW-SW-1:0] y_d;
            logic             cm_unused;

            // Only the final slice's MSB carry feeds the overflow flag.
            assign cm_unused = cm;

            always_comb begin
                x_d = en ? xi[RW-1:SW] : x_q;
                y_d = en ? yi[RW-1:SW] : y_q;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    x_q <= '0;
                    y_q <= '0;
                end else begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end
        end else begin : g_tail
            logic cmsb_q;
            logic cmsb_d;
            logic zero_q;
            logic zero_d;

            // Zero is registered so it reads 0 out of reset rather than NOR of a cleared sum.
            always_comb begin
                cmsb_d = en ? cm         : cmsb_q;
                zero_d = en ? ~|res_new  : zero_q;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cmsb_q <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    cmsb_q <= cmsb_d;
                    zero_q <= zero_d;
                end
            end

            assign out_valid = valid_q;
            assign sum       = res_q;
            assign cout      = carry_q;
            assign ovf       = carry_q ^ cmsb_q;
            assign zero      = zero_q;
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - directed and randomized checks of add_pipe across several geometries
module tb_add_pipe;
    import add_pipe_pkg::*;

    localparam int NCFG = 5;

    function automatic int cfg_w(int g);
        case (g)
            3:       return 32;
            4:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_s(int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    // Reference: plain modular and signed integer arithmetic on the operands.
    function automatic res_t model(int w, logic [31:0] xa, logic [31:0] xb, logic c, logic [1:0] m);
        longint unsigned mask, ua, ub, t, hu;
        longint          sa, sb, r, hs;
        res_t            e;
        mask = (64'd1 << w) - 64'd1;
        hu   = 64'd1 << (w - 1);
        hs   = longint'(hu);
        ua   = {32'd0, xa} & mask;
        ub   = {32'd0, xb} & mask;
        sa   = (ua >= hu) ? longint'(ua) - 2 * hs : longint'(ua);
        sb   = (ub >= hu) ? longint'(ub) - 2 * hs : longint'(ub);
        e    = '0;
        case (m)
            2'd0: begin
                t = ua + ub + {63'd0, c};
                e.cout = ((t >> w) & 64'd1) != 0;
                r = sa + sb + longint'({63'd0, c});
            end
            2'd1: begin
                t = ua + 64'd1;
                e.cout = (ua == mask);
                r = sa + 1;
            end
            2'd2: begin
                t = ua - ub;
                e.cout = (ua >= ub);
                r = sa - sb;
            end
            default: begin
                t = ua - 64'd1;
                e.cout = (ua != 0);
                r = sa - 1;
            end
        endcase
        e.sum  = 32'(t & mask);
        e.ovf  = (r > hs - 1) || (r < -hs);
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [1:0]  mode;
    logic        out_ready;
    logic        done;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);

        logic         in_ready_o;
        logic         out_valid_o;
        logic [W-1:0] sum_o;
        logic         cout_o;
        logic         ovf_o;
        logic         zero_o;
        res_t         exp_q[$];
        res_t         got;
        res_t         want;

        add_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clock     (clk),
            .reset     (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_o),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .cin       (cin),
            .mode      (mode),
            .out_valid (out_valid_o),
            .out_ready (out_ready),
            .sum       (sum_o),
            .cout      (cout_o),
            .ovf       (ovf_o),
            .zero      (zero_o)
        );

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                checks++;
                assert (in_ready_o === (!out_valid_o || out_ready)) else begin
                    errors++;
                    $error("FAIL cfg%0d_in_ready observed=%b expected=%b", g, in_ready_o, !out_valid_o || out_ready);
                end
                if (out_valid_o) begin
                    got = '0;
                    got.sum  = 32'(sum_o);
                    got.cout = cout_o;
                    got.ovf  = ovf_o;
                    got.zero = zero_o;
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL cfg%0d_spurious observed=%h expected=no result", g, got);
                    end
                    if (exp_q.size() != 0) begin
                        want = exp_q[0];
                        checks++;
                        assert (got === want) else begin
                            errors++;
                            $error("FAIL cfg%0d_result observed=%h expected=%h", g, got, want);
                        end
                        if (out_ready) exp_q.pop_front();
                    end
                end
                if (in_valid && in_ready_o) exp_q.push_back(model(W, a, b, cin, mode));
            end
        end

        always @(posedge done) begin
            checks++;
            assert (exp_q.size() == 0) else begin
                errors++;
                $error("FAIL cfg%0d_lost observed=%0d pending expected=0", g, exp_q.size());
            end
        end
    end

    logic        ov0;
    logic        ir0;
    logic [15:0] sum0;
    logic        cout0;
    logic        ovf0;
    logic        zero0;
    assign ov0   = g_cfg[0].out_valid_o;
    assign ir0   = g_cfg[0].in_ready_o;
    assign sum0  = g_cfg[0].sum_o;
    assign cout0 = g_cfg[0].cout_o;
    assign ovf0  = g_cfg[0].ovf_o;
    assign zero0 = g_cfg[0].zero_o;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(string tag, logic [1:0] m, logic [31:0] xa, logic [31:0] xb, logic c,
                          logic [15:0] es, logic ec, logic eo, logic ez);
        int n;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = c;
        mode = m;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!ov0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_sum"}, {16'd0, sum0}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout0}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf0}, {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero0}, {31'd0, ez});
    endtask

    int          idx;
    int          cyc;
    logic        stall;
    logic [15:0] rcv[$];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        mode = MODE_ADD;
        out_ready = 1'b1;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, ov0}, 0);
        check("reset_sum", {16'd0, sum0}, 0);
        check("reset_cout", {31'd0, cout0}, 0);
        check("reset_ovf", {31'd0, ovf0}, 0);
        check("reset_zero", {31'd0, zero0}, 0);
        rst = 1'b0;

        run_op("add_carry", MODE_ADD, 32'h00FF, 32'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",  MODE_ADD, 32'hFFFF, 32'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",   MODE_ADD, 32'h7FFF, 32'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_cin",   MODE_ADD, 32'h1234, 32'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0);
        run_op("inc_wrap",  MODE_INC, 32'hFFFF, 32'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg",   MODE_SUB, 32'h0005, 32'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",   MODE_SUB, 32'h8000, 32'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("dec_wrap",  MODE_DEC, 32'h0000, 32'h1234, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        idx = 1;
        cyc = 0;
        rcv.delete();
        while (rcv.size() < 8 && cyc < 60) begin
            stall = (cyc >= 5 && cyc < 11);
            out_ready = !stall;
            in_valid = (idx <= 8);
            a = idx;
            b = idx;
            cin = 1'b0;
            mode = MODE_ADD;
            @(negedge clk);
            if (stall) begin
                check("bp_in_ready", {31'd0, ir0}, 0);
                check("bp_stall_valid", {31'd0, ov0}, 1);
                check("bp_stall_sum", {16'd0, sum0}, 2 * (rcv.size() + 1));
            end
            if (ov0 && out_ready) rcv.push_back(sum0);
            if (in_valid && ir0) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", rcv.size(), 8);
        for (int i = 0; i < rcv.size(); i++) check("bp_order", {16'd0, rcv[i]}, 2 * (i + 1));

        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 10 + k;
            b = 1;
            mode = MODE_ADD;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, ov0}, 0);
        check("rst_async_sum", {16'd0, sum0}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_stale", {31'd0, ov0}, 0);
        end
        run_op("rst_new_op", MODE_ADD, 32'h0003, 32'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'hFFFF_FFFF;
                1: a = 32'h0000_0000;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_8080;
                default: ;
            endcase
            cin = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        done = 1'b1;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
